// File: rtl/cdb_arbiter_if.sv
// Result-producer and CDB broadcast signals for cdb_arbiter.
// The arbiter takes the slave side; producers and CDB consumers use the master side.
interface cdb_arbiter_if #(
    parameter int LAB_W = 5,
    parameter int VAL_W = 32
) ();
    logic             alu_valid;
    logic [LAB_W-1:0] alu_lab;
    logic [VAL_W-1:0] alu_val;
    logic             alu_ready;

    logic             lsb_valid;
    logic [LAB_W-1:0] lsb_lab;
    logic [VAL_W-1:0] lsb_val;
    logic             lsb_ready;

    logic             cdb_valid;
    logic [LAB_W-1:0] cdb_lab;
    logic [VAL_W-1:0] cdb_val;
    logic             cdb_src;

    modport master (
        output alu_valid, alu_lab, alu_val,
        input  alu_ready,
        output lsb_valid, lsb_lab, lsb_val,
        input  lsb_ready,
        input  cdb_valid, cdb_lab, cdb_val, cdb_src
    );

    modport slave (
        input  alu_valid, alu_lab, alu_val,
        output alu_ready,
        input  lsb_valid, lsb_lab, lsb_val,
        output lsb_ready,
        output cdb_valid, cdb_lab, cdb_val, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one small FIFO per producer (ALU, LSB), one registered broadcast per cycle.
// Define CDB_BYPASS_EN to let a request into an empty FIFO compete for the bus on the same edge.
module cdb_arbiter #(
    parameter int LAB_W = 5,
    parameter int VAL_W = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         flush,
    cdb_arbiter_if.slave bus
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int NSRC    = 2;
    localparam int SRC_ALU = 0;
    localparam int SRC_LSB = 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [LAB_W-1:0] lab_t;
    typedef logic [VAL_W-1:0] val_t;

    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_LSB = 1'b1
    } prio_e;

    lab_t  mem_lab_q [NSRC][DEPTH];
    lab_t  mem_lab_d [NSRC][DEPTH];
    val_t  mem_val_q [NSRC][DEPTH];
    val_t  mem_val_d [NSRC][DEPTH];
    ptr_t  head_q    [NSRC];
    ptr_t  head_d    [NSRC];
    ptr_t  tail_q    [NSRC];
    ptr_t  tail_d    [NSRC];
    cnt_t  count_q   [NSRC];
    cnt_t  count_d   [NSRC];
    prio_e rr_prio_q, rr_prio_d;
    logic  cdb_valid_q, cdb_valid_d;
    lab_t  cdb_lab_q, cdb_lab_d;
    val_t  cdb_val_q, cdb_val_d;
    logic  cdb_src_q, cdb_src_d;

    logic  in_valid  [NSRC];
    lab_t  in_lab    [NSRC];
    val_t  in_val    [NSRC];
    logic  ready     [NSRC];
    logic  push_req  [NSRC];
    logic  cand      [NSRC];
    logic  cand_byp  [NSRC];
    lab_t  cand_lab  [NSRC];
    val_t  cand_val  [NSRC];
    logic  do_push   [NSRC];
    logic  do_pop    [NSRC];
    logic  grant_v;
    logic  grant_src;

    always_comb begin : src_map
        in_valid[SRC_ALU] = bus.alu_valid;
        in_lab[SRC_ALU]   = bus.alu_lab;
        in_val[SRC_ALU]   = bus.alu_val;
        in_valid[SRC_LSB] = bus.lsb_valid;
        in_lab[SRC_LSB]   = bus.lsb_lab;
        in_val[SRC_LSB]   = bus.lsb_val;
    end

    // Ready looks only at the registered count, so a pop on this edge never frees a slot early.
    always_comb begin : req_logic
        for (int unsigned s = 0; s < NSRC; s++) begin
            ready[s]    = rdy_in && (count_q[s] < CNT_W'(DEPTH));
            push_req[s] = in_valid[s] && ready[s] && !flush && (in_lab[s] != '0);
        end
    end

    always_comb begin : arbitration
        for (int unsigned s = 0; s < NSRC; s++) begin
            cand[s]     = (count_q[s] != '0);
            cand_byp[s] = 1'b0;
            cand_lab[s] = mem_lab_q[s][head_q[s]];
            cand_val[s] = mem_val_q[s][head_q[s]];
`ifdef CDB_BYPASS_EN
            if ((count_q[s] == '0) && push_req[s]) begin
                cand[s]     = 1'b1;
                cand_byp[s] = 1'b1;
                cand_lab[s] = in_lab[s];
                cand_val[s] = in_val[s];
            end
`endif
        end

        grant_v = cand[SRC_ALU] || cand[SRC_LSB];
        if (cand[SRC_ALU] && cand[SRC_LSB]) begin
            grant_src = (rr_prio_q == PRIO_LSB);
        end else begin
            grant_src = !cand[SRC_ALU];
        end

        // A bypassed winner goes straight to the bus and is never written into its FIFO.
        for (int unsigned s = 0; s < NSRC; s++) begin
            do_pop[s]  = grant_v && (grant_src == s[0]) && !cand_byp[s];
            do_push[s] = push_req[s] && !(grant_v && (grant_src == s[0]) && cand_byp[s]);
        end
    end

    always_comb begin : next_state
        mem_lab_d   = mem_lab_q;
        mem_val_d   = mem_val_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        rr_prio_d   = rr_prio_q;
        cdb_valid_d = cdb_valid_q;
        cdb_lab_d   = cdb_lab_q;
        cdb_val_d   = cdb_val_q;
        cdb_src_d   = cdb_src_q;

        if (rdy_in) begin
            if (flush) begin
                for (int unsigned s = 0; s < NSRC; s++) begin
                    head_d[s]  = '0;
                    tail_d[s]  = '0;
                    count_d[s] = '0;
                end
                cdb_valid_d = 1'b0;
            end else begin
                cdb_valid_d = grant_v;
                if (grant_v) begin
                    cdb_lab_d = cand_lab[grant_src];
                    cdb_val_d = cand_val[grant_src];
                    cdb_src_d = grant_src;
                    rr_prio_d = grant_src ? PRIO_ALU : PRIO_LSB;
                end

                for (int unsigned s = 0; s < NSRC; s++) begin
                    if (do_push[s]) begin
                        mem_lab_d[s][tail_q[s]] = in_lab[s];
                        mem_val_d[s][tail_q[s]] = in_val[s];
                        tail_d[s]               = tail_q[s] + ptr_t'(1);
                    end
                    if (do_pop[s]) begin
                        head_d[s] = head_q[s] + ptr_t'(1);
                    end
                    case ({do_push[s], do_pop[s]})
                        2'b10:   count_d[s] = count_q[s] + cnt_t'(1);
                        2'b01:   count_d[s] = count_q[s] - cnt_t'(1);
                        default: count_d[s] = count_q[s];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_in) begin
            mem_lab_q   <= '{default: '0};
            mem_val_q   <= '{default: '0};
            head_q      <= '{default: '0};
            tail_q      <= '{default: '0};
            count_q     <= '{default: '0};
            rr_prio_q   <= PRIO_ALU;
            cdb_valid_q <= 1'b0;
            cdb_lab_q   <= '0;
            cdb_val_q   <= '0;
            cdb_src_q   <= 1'b0;
        end else begin
            mem_lab_q   <= mem_lab_d;
            mem_val_q   <= mem_val_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rr_prio_q   <= rr_prio_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_lab_q   <= cdb_lab_d;
            cdb_val_q   <= cdb_val_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign bus.alu_ready = ready[SRC_ALU];
    assign bus.lsb_ready = ready[SRC_LSB];
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_lab   = cdb_lab_q;
    assign bus.cdb_val   = cdb_val_q;
    assign bus.cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic against a queue-based model.
// Honours CDB_BYPASS_EN the same way the design does.
module tb_cdb_arbiter;

    localparam int LAB_W = 5;
    localparam int VAL_W = 32;
    localparam int DEPTH = 2;
`ifdef CDB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
    localparam int LAT    = 1;
`else
    localparam bit BYPASS = 1'b0;
    localparam int LAT    = 2;
`endif

    typedef logic [LAB_W-1:0] lab_t;
    typedef logic [VAL_W-1:0] val_t;
    typedef struct packed {
        lab_t lab;
        val_t val;
    } res_t;

    logic clk = 1'b0;
    logic rst_in, rdy_in, flush;

    cdb_arbiter_if #(.LAB_W(LAB_W), .VAL_W(VAL_W)) bus ();

    cdb_arbiter #(.LAB_W(LAB_W), .VAL_W(VAL_W), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per producer, a priority bit, and the expected bus registers.
    res_t qa[$];
    res_t ql[$];
    logic m_prio;
    logic e_valid;
    lab_t e_lab;
    val_t e_val;
    logic e_src;
    logic m_acc_a, m_acc_l;

    int   n_checks = 0;
    int   n_errors = 0;
    lab_t obs[$];

    task automatic model_step();
        res_t ra, rl, win;
        logic acc_a, acc_l, ca, cl, ba, bl, any, g, push_a, push_l;
        ra.lab = bus.alu_lab;  ra.val = bus.alu_val;
        rl.lab = bus.lsb_lab;  rl.val = bus.lsb_val;
        m_acc_a = 1'b0;
        m_acc_l = 1'b0;
        if (!rst_in) begin
            qa.delete(); ql.delete();
            m_prio = 1'b0; e_valid = 1'b0; e_lab = '0; e_val = '0; e_src = 1'b0;
        end else if (rdy_in && flush) begin
            qa.delete(); ql.delete();
            e_valid = 1'b0;
        end else if (rdy_in) begin
            acc_a = bus.alu_valid && (qa.size() < DEPTH) && (bus.alu_lab != '0);
            acc_l = bus.lsb_valid && (ql.size() < DEPTH) && (bus.lsb_lab != '0);
            ca = (qa.size() > 0); cl = (ql.size() > 0);
            ba = 1'b0; bl = 1'b0;
            if (BYPASS && qa.size() == 0 && acc_a) begin ca = 1'b1; ba = 1'b1; end
            if (BYPASS && ql.size() == 0 && acc_l) begin cl = 1'b1; bl = 1'b1; end
            any = ca || cl;
            g = (ca && cl) ? m_prio : !ca;
            push_a = acc_a;
            push_l = acc_l;
            e_valid = any;
            if (any) begin
                if (!g) begin
                    if (ba) begin win = ra; push_a = 1'b0; end
                    else win = qa.pop_front();
                end else begin
                    if (bl) begin win = rl; push_l = 1'b0; end
                    else win = ql.pop_front();
                end
                e_lab = win.lab; e_val = win.val; e_src = g; m_prio = !g;
            end
            if (push_a) qa.push_back(ra);
            if (push_l) ql.push_back(rl);
            m_acc_a = acc_a;
            m_acc_l = acc_l;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic av, input lab_t al, input logic lv, input lab_t ll);
        bus.alu_valid = av; bus.alu_lab = al; bus.alu_val = $urandom;
        bus.lsb_valid = lv; bus.lsb_lab = ll; bus.lsb_val = $urandom;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0;
        drive(1'b1, 5'd5, 1'b0, '0);
        tick();
        tick();
        rst_in = 1'b1;
        drive(1'b0, '0, 1'b0, '0);
        #1;
        n_checks++;
        if ({bus.cdb_valid, bus.cdb_lab} !== {1'b0, 5'd0}) begin
            n_errors++; $display("FAIL reset_cdb: got v=%0b lab=%0d want v=0 lab=0", bus.cdb_valid, bus.cdb_lab);
        end
        n_checks++;
        if (bus.alu_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_alu_ready: got %0b want 1", bus.alu_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.cdb_valid !== 1'b0) begin
                n_errors++; $display("FAIL reset_idle: cdb_valid got %0b want 0", bus.cdb_valid);
            end
        end
    endtask

    task automatic test_single_alu();
        drive(1'b1, 5'd3, 1'b0, '0);
        bus.alu_val = 32'h1234;
        #1;
        n_checks++;
        if (bus.alu_ready !== 1'b1) begin
            n_errors++; $display("FAIL single_ready: got %0b want 1", bus.alu_ready);
        end
        tick();
        drive(1'b0, '0, 1'b0, '0);
        for (int k = 1; k <= 3; k++) begin
            n_checks++;
            if (bus.cdb_valid !== (k == LAT)) begin
                n_errors++; $display("FAIL single_valid: edge+%0d got %0b want %0b", k - 1, bus.cdb_valid, (k == LAT));
            end
            if (k == LAT) begin
                n_checks++;
                if ({bus.cdb_lab, bus.cdb_val, bus.cdb_src} !== {5'd3, 32'h1234, 1'b0}) begin
                    n_errors++; $display("FAIL single_data: got lab=%0d val=%h src=%0b want lab=3 val=1234 src=0",
                                         bus.cdb_lab, bus.cdb_val, bus.cdb_src);
                end
            end
            tick();
        end
        n_checks++;
        if ({bus.cdb_valid, bus.cdb_lab, bus.cdb_val, bus.cdb_src} !== {e_valid, e_lab, e_val, e_src}) begin
            n_errors++; $display("FAIL single_model: got %h want %h",
                                 {bus.cdb_valid, bus.cdb_lab, bus.cdb_val, bus.cdb_src}, {e_valid, e_lab, e_val, e_src});
        end
    endtask

    task automatic test_contention();
        int   ia, il;
        logic saw_full;
        lab_t want;
        rst_in = 1'b0; drive(1'b0, '0, 1'b0, '0); tick(); rst_in = 1'b1;
        ia = 1; il = 9; saw_full = 1'b0; obs.delete();
        for (int cyc = 0; cyc < 40; cyc++) begin
            drive(ia <= 6, LAB_W'(ia), il <= 14, LAB_W'(il));
            #1;
            n_checks++;
            if ({bus.alu_ready, bus.lsb_ready} !== {rdy_in && (qa.size() < DEPTH), rdy_in && (ql.size() < DEPTH)}) begin
                n_errors++; $display("FAIL contention_ready: got %b%b want %b%b", bus.alu_ready, bus.lsb_ready,
                                     rdy_in && (qa.size() < DEPTH), rdy_in && (ql.size() < DEPTH));
            end
            if (bus.lsb_valid && !bus.lsb_ready) saw_full = 1'b1;
            tick();
            if (m_acc_a) ia++;
            if (m_acc_l) il++;
            n_checks++;
            if ({bus.cdb_valid, bus.cdb_lab, bus.cdb_val, bus.cdb_src} !== {e_valid, e_lab, e_val, e_src}) begin
                n_errors++; $display("FAIL contention_cdb: got %h want %h",
                                     {bus.cdb_valid, bus.cdb_lab, bus.cdb_val, bus.cdb_src}, {e_valid, e_lab, e_val, e_src});
            end
            if (bus.cdb_valid) obs.push_back(bus.cdb_lab);
            if (ia > 6 && il > 14 && qa.size() == 0 && ql.size() == 0) break;
        end
        drive(1'b0, '0, 1'b0, '0);
        n_checks++;
        if (obs.size() !== 12) begin
            n_errors++; $display("FAIL contention_count: got %0d broadcasts want 12", obs.size());
        end
        for (int k = 0; k < obs.size(); k++) begin
            want = (k % 2 == 0) ? LAB_W'(1 + k / 2) : LAB_W'(9 + k / 2);
            n_checks++;
            if (obs[k] !== want) begin
                n_errors++; $display("FAIL contention_order[%0d]: got %0d want %0d", k, obs[k], want);
            end
        end
        n_checks++;
        if (saw_full !== 1'b1) begin
            n_errors++; $display("FAIL contention_lsb_full: lsb_ready low seen=%0b want 1", saw_full);
        end
    endtask

    task automatic test_full_fifo();
        int   ia, il;
        logic saw_full;
        rst_in = 1'b0; drive(1'b0, '0, 1'b0, '0); tick(); rst_in = 1'b1;
        ia = 1; il = 16; saw_full = 1'b0; obs.delete();
        for (int cyc = 0; cyc < 40; cyc++) begin
            drive(ia <= 4, LAB_W'(ia), 1'b1, LAB_W'(il));
            #1;
            n_checks++;
            if (bus.alu_ready !== (rdy_in && (qa.size() < DEPTH))) begin
                n_errors++; $display("FAIL full_alu_ready: got %0b want %0b", bus.alu_ready, rdy_in && (qa.size() < DEPTH));
            end
            if (bus.alu_valid && !bus.alu_ready) saw_full = 1'b1;
            tick();
            if (m_acc_a) ia++;
            if (m_acc_l) il = (il == 31) ? 16 : il + 1;
            n_checks++;
            if ({bus.cdb_valid, bus.cdb_lab, bus.cdb_val, bus.cdb_src} !== {e_valid, e_lab, e_val, e_src}) begin
                n_errors++; $display("FAIL full_cdb: got %h want %h",
                                     {bus.cdb_valid, bus.cdb_lab, bus.cdb_val, bus.cdb_src}, {e_valid, e_lab, e_val, e_src});
            end
            if (bus.cdb_valid && !bus.cdb_src) obs.push_back(bus.cdb_lab);
            if (ia > 4 && qa.size() == 0) break;
        end
        drive(1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({bus.cdb_valid, bus.cdb_lab, bus.cdb_val, bus.cdb_src} !== {e_valid, e_lab, e_val, e_src}) begin
                n_errors++; $display("FAIL full_drain: got %h want %h",
                                     {bus.cdb_valid, bus.cdb_lab, bus.cdb_val, bus.cdb_src}, {e_valid, e_lab, e_val, e_src});
            end
        end
        n_checks++;
        if (ia !== 5) begin
            n_errors++; $display("FAIL full_accept: ALU pushes accepted got %0d want 4", ia - 1);
        end
        n_checks++;
        if (obs.size() !== 4) begin
            n_errors++; $display("FAIL full_alu_count: got %0d ALU broadcasts want 4", obs.size());
        end
        for (int k = 0; k < obs.size(); k++) begin
            n_checks++;
            if (obs[k] !== LAB_W'(k + 1)) begin
                n_errors++; $display("FAIL full_alu_order[%0d]: got %0d want %0d", k, obs[k], k + 1);
            end
        end
        n_checks++;
        if (saw_full !== (LAT == 2)) begin
            n_errors++; $display("FAIL full_ready_drop: alu_ready low seen=%0b want %0b", saw_full, (LAT == 2));
        end
    endtask

    task automatic test_flush();
        rst_in = 1'b0; drive(1'b0, '0, 1'b0, '0); tick(); rst_in = 1'b1;
        drive(1'b1, 5'd4, 1'b1, 5'd12); tick();
        drive(1'b1, 5'd5, 1'b1, 5'd13); tick();
        flush = 1'b1;
        drive(1'b1, 5'd7, 1'b0, '0);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, 1'b0, '0);
        #1;
        n_checks++;
        if ({bus.cdb_valid, bus.alu_ready, bus.lsb_ready} !== 3'b011) begin
            n_errors++; $display("FAIL flush_state: got valid=%0b ready=%b%b want valid=0 ready=11",
                                 bus.cdb_valid, bus.alu_ready, bus.lsb_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({bus.cdb_valid, e_valid} !== 2'b00) begin
                n_errors++; $display("FAIL flush_idle: got cdb_valid=%0b model=%0b want 0", bus.cdb_valid, e_valid);
            end
        end
    endtask

    task automatic test_stall_label0();
        rst_in = 1'b0; drive(1'b0, '0, 1'b0, '0); tick(); rst_in = 1'b1;
        drive(1'b1, 5'd2, 1'b1, 5'd10); tick();
        drive(1'b1, 5'd3, 1'b0, '0); tick();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            drive(1'b1, 5'd6, 1'b1, 5'd11);
            #1;
            n_checks++;
            if ({bus.alu_ready, bus.lsb_ready} !== 2'b00) begin
                n_errors++; $display("FAIL stall_ready: got %b%b want 00", bus.alu_ready, bus.lsb_ready);
            end
            tick();
            n_checks++;
            if ({bus.cdb_valid, bus.cdb_lab, bus.cdb_val, bus.cdb_src} !== {e_valid, e_lab, e_val, e_src}) begin
                n_errors++; $display("FAIL stall_hold: got %h want %h",
                                     {bus.cdb_valid, bus.cdb_lab, bus.cdb_val, bus.cdb_src}, {e_valid, e_lab, e_val, e_src});
            end
        end
        flush = 1'b0;
        rdy_in = 1'b1;
        drive(1'b1, '0, 1'b0, '0);
        bus.alu_val = 32'hdead;
        tick();
        drive(1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({bus.cdb_valid, bus.cdb_lab, bus.cdb_val, bus.cdb_src} !== {e_valid, e_lab, e_val, e_src}) begin
                n_errors++; $display("FAIL label0_cdb: got %h want %h",
                                     {bus.cdb_valid, bus.cdb_lab, bus.cdb_val, bus.cdb_src}, {e_valid, e_lab, e_val, e_src});
            end
            n_checks++;
            if ((bus.cdb_valid && bus.cdb_lab == '0) !== 1'b0) begin
                n_errors++; $display("FAIL label0_broadcast: label 0 seen on bus, val=%h", bus.cdb_val);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst_in = ($urandom_range(0, 149) != 0);
            rdy_in = ($urandom_range(0, 7) != 0);
            flush  = ($urandom_range(0, 24) == 0);
            drive($urandom_range(0, 2) != 0, LAB_W'($urandom_range(0, 31)),
                  $urandom_range(0, 2) != 0, LAB_W'($urandom_range(0, 31)));
            #1;
            n_checks++;
            if ({bus.alu_ready, bus.lsb_ready} !== {rdy_in && (qa.size() < DEPTH), rdy_in && (ql.size() < DEPTH)}) begin
                n_errors++; $display("FAIL random_ready@%0d: got %b%b want %b%b", cyc, bus.alu_ready, bus.lsb_ready,
                                     rdy_in && (qa.size() < DEPTH), rdy_in && (ql.size() < DEPTH));
            end
            tick();
            n_checks++;
            if ({bus.cdb_valid, bus.cdb_lab, bus.cdb_val, bus.cdb_src} !== {e_valid, e_lab, e_val, e_src}) begin
                n_errors++; $display("FAIL random_cdb@%0d: got %h want %h", cyc,
                                     {bus.cdb_valid, bus.cdb_lab, bus.cdb_val, bus.cdb_src}, {e_valid, e_lab, e_val, e_src});
            end
        end
        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
        drive(1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0;
        drive(1'b0, '0, 1'b0, '0);
        m_prio = 1'b0; e_valid = 1'b0; e_lab = '0; e_val = '0; e_src = 1'b0;
        m_acc_a = 1'b0; m_acc_l = 1'b0;
        test_reset();
        test_single_alu();
        test_contention();
        test_full_fifo();
        test_flush();
        test_stall_label0();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
